// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional backpressure stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_fire, out_fire;

  // Ready comes straight from the state register, so it never depends on out_ready.
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = StFull;
          end
        end
        StFull: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = StSkid;
          end else if (out_fire) begin
            main_ctrl_d = '0;
            state_d     = StEmpty;
          end
        end
        StSkid: begin
          // Skid entry is older than anything upstream, so it moves up first.
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = StFull;
          end
        end
        default: begin
          state_d     = StEmpty;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating; only reset clears it, flush leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic [CNT_W-1:0] unused_stall_cnt;
  assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; stall counter checks run when
// PIPE_STALL_CNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned DataW = 32;
  localparam int unsigned CtrlW = 16;
  localparam int unsigned CntW  = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DataW-1:0] in_data;
  logic [CtrlW-1:0] in_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] out_data;
  logic [CtrlW-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
  logic [CntW-1:0]  stall_cnt;
`endif

  int n_checks;
  int n_fails;

  pipe_stage_skid #(
    .DATA_W(DataW),
    .CTRL_W(CtrlW),
    .CNT_W (CntW)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DataW-1:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = {8'hC0, d[7:0]};
    out_ready = rdy;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    drive(1'b0, '0, 1'b0);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    step();
    rst_n = 1'b1;

    // Streaming at full rate
    drive(1'b1, 32'h11, 1'b1);
    step();
    check("str1_valid", out_valid, 1);
    check("str1_data", out_data, 32'h11);
    check("str1_ctrl", out_ctrl, 16'hC011);
    check("str1_in_ready", in_ready, 1);
    drive(1'b1, 32'h22, 1'b1);
    step();
    check("str2_data", out_data, 32'h22);
    check("str2_in_ready", in_ready, 1);
    drive(1'b1, 32'h33, 1'b1);
    step();
    check("str3_data", out_data, 32'h33);
    check("str3_ctrl", out_ctrl, 16'hC033);

    // Drain: data holds, ctrl clears
    drive(1'b0, 32'h99, 1'b1);
    step();
    check("drain_valid", out_valid, 0);
    check("drain_ctrl", out_ctrl, 0);
    check("drain_data_hold", out_data, 32'h33);

    // Backpressure into skid
    drive(1'b1, 32'hA, 1'b0);
    step();
    check("bp_full_data", out_data, 32'hA);
    check("bp_full_in_ready", in_ready, 1);
    drive(1'b1, 32'hB, 1'b0);
    step();
    check("bp_skid_in_ready", in_ready, 0);
    check("bp_skid_data", out_data, 32'hA);
    check("bp_skid_ctrl", out_ctrl, 16'hC00A);
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("bp_release_data", out_data, 32'hA);
    step();
    check("bp_second_data", out_data, 32'hB);
    check("bp_second_ctrl", out_ctrl, 16'hC00B);
    check("bp_in_ready_back", in_ready, 1);
    step();
    check("bp_empty", out_valid, 0);

    // Flush while in skid with 0xC offered
    drive(1'b1, 32'hD, 1'b0);
    step();
    drive(1'b1, 32'hE, 1'b0);
    step();
    check("fl_pre_in_ready", in_ready, 0);
    drive(1'b1, 32'hC, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_in_ready", in_ready, 1);
    drive(1'b0, 32'h0, 1'b1);
    step();
    check("fl_no_c", out_valid, 0);
    drive(1'b1, 32'h5, 1'b1);
    step();
    check("fl_recover_data", out_data, 32'h5);
    check("fl_recover_valid", out_valid, 1);

    // Async reset between edges while in skid
    drive(1'b1, 32'h1, 1'b0);
    step();
    drive(1'b1, 32'h2, 1'b0);
    step();
    check("ar_pre_in_ready", in_ready, 0);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_data", out_data, 0);
    step();
    rst_n = 1'b1;

`ifdef PIPE_STALL_CNT_EN
    check("sc_reset", stall_cnt, 0);
    drive(1'b1, 32'h7, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    check("sc_load", stall_cnt, 0);
    for (int i = 0; i < 5; i++) step();
    check("sc_five", stall_cnt, 5);
    for (int i = 0; i < 15; i++) step();
    check("sc_sat", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sc_flush_keep", stall_cnt, 15);
    check("sc_flush_valid", out_valid, 0);
    step();
    check("sc_idle_keep", stall_cnt, 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register, generalising the fixed ID/EX latch into a stage usable at any pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept while backpressure propagates with a registered ready.
- Supports synchronous flush to insert bubbles.
- Carries an opaque data bundle (operands, immediates, register indices) and a control bundle (ALU function, mux selects, mem/regfile write enables). The control bundle is forced to zero whenever the stage holds no valid entry, so downstream never sees stray write enables.

Parameters:
DATA_W, 32, width of the data bundle (must be >= 1)
CTRL_W, 16, width of the control bundle (must be >= 1)
CNT_W, 16, width of the stall counter (used only with PIPE_STALL_CNT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  stage presents a valid entry
out_ready  in  1  downstream accepts the entry this cycle
out_data  out  DATA_W  presented data bundle
out_ctrl  out  CTRL_W  presented control bundle; all-zero when out_valid=0
stall_cnt  out  CNT_W  backpressure stall cycles (present only with PIPE_STALL_CNT_EN)

Behaviour:
- Clock, reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives the out_* ports) and a skid register.
- State machine: states EMPTY, FULL, SKID. in_ready = (state != SKID), decoded directly from the state register with no combinational path from out_ready. out_valid = (state != EMPTY).
- Reset (rst_n low, asynchronous): state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, skid contents=0, stall_cnt=0.
- EMPTY:
  - in_fire -> load main, go FULL.
  - otherwise stay.
- FULL:
  - in_fire & out_fire -> load main with input, stay FULL.
  - in_fire & !out_fire -> load skid, go SKID.
  - !in_fire & out_fire -> go EMPTY, out_ctrl <= 0.
  - neither -> hold.
- SKID (in_ready=0):
  - out_fire -> main <= skid, go FULL.
  - otherwise hold both entries.
- Latency and throughput: 1 cycle from in_fire to out_valid when empty; sustained throughput 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO. The skid entry is always older than any subsequent input.
- Flush: highest priority, evaluated at the clock edge.
  - state -> EMPTY, out_ctrl <= 0; out_data holds its value (don't-care).
  - Any in_fire or out_fire in the flush cycle is discarded. Upstream sees in_ready=1, so it must itself treat that entry as killed.
- out_data/out_ctrl are stable while out_valid=1 and out_ready=0.
- Reset mid-operation: both entries are lost immediately; outputs take their reset values asynchronously.
- No X or Z is ever driven on any output.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[CNT_W-1:0].
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at all-ones; does not wrap.
  - Cleared only by rst_n; flush does not clear it.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then streaming: in_valid=1 with data 0x11,0x22,0x33 and out_ready=1 -> out_valid rises 1 cycle after first accept; out_data = 0x11,0x22,0x33 on consecutive cycles; in_ready stays 1.
- Backpressure: FULL with 0xA, accept 0xB with out_ready=0 -> state SKID, in_ready=0 next cycle; raise out_ready -> out_data = 0xA then 0xB; in_ready returns 1 after the first out_fire.
- Flush in SKID with in_valid=1 presenting 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xC never appears at the output.
- Drain: FULL, in_valid=0, out_ready=1 -> next cycle out_valid=0 and out_ctrl=0 while out_data holds its last value.
- Async reset mid-SKID: rst_n pulsed low between edges -> out_valid=0, out_ctrl=0, in_ready=1 immediately, without waiting for a clock edge.
- PIPE_STALL_CNT_EN defined, CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt = 15 (saturated); then flush -> stall_cnt stays 15.
